j4: RTL and testbench

- 16-bit J1-style dual-stack Forth CPU core.
- Fetches one 16-bit instruction per cycle from word address pc.
- Executes literal, jump, conditional-jump, call and ALU instructions in a single cycle.
- Reaches data memory/IO through a simple registered read/write port; the external memory owns the RAM.

---
 rtl/j4_pkg.sv | 47 ++++
 rtl/j4_stack.sv | 38 +++
 rtl/j4.sv | 153 +++++++++++++++
 tb/tb_j4.sv | 139 +++++++++++++
 4 files changed

// File: rtl/j4_pkg.sv
// j4 shared definitions: instruction classes, ALU ops, field positions.
// Default WIDTH/DEPTH and the stack-delta decode live here too.
package j4_pkg;

   localparam int WIDTH_DEF = 16;
   localparam int DEPTH_DEF = 5;
   localparam int PC_W      = 13;

   localparam int B_LIT = 15;
   localparam int B_RPC = 12;
   localparam int B_TN  = 7;
   localparam int B_TR  = 6;
   localparam int B_WE  = 5;
   localparam int B_RE  = 4;

   typedef enum logic [2:0] {
      LIT, JMP, JZ, CALL, ALU
   } cls_t;

   typedef enum logic [3:0] {
      OP_T, OP_N, OP_ADD, OP_AND,
      OP_OR, OP_XOR, OP_INV, OP_EQ,
      OP_LT, OP_SHR, OP_DEC, OP_R,
      OP_IO, OP_SHL, OP_SP, OP_ULT
   } alu_op_t;

   function automatic cls_t decode_cls(input logic [15:0] i);
      cls_t c;
      if (i[B_LIT])
         c = LIT;
      else begin
         unique case (i[14:13])
            2'b00: c = JMP;
            2'b01: c = JZ;
            2'b10: c = CALL;
            default: c = ALU;
         endcase
      end
      return c;
   endfunction

   // 2-bit signed delta: 00 0, 01 +1, 10 -2, 11 -1
   function automatic int stack_delta(input logic [1:0] d);
      return int'($signed(d));
   endfunction

endpackage

// File: rtl/j4_stack.sv
// j4 stack: register array plus pointer, moved by a signed delta.
// top always reads the pre-update entry, so a same-cycle push sees old data.
module j4_stack
   import j4_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       delta,
   input  logic             we,
   input  logic [WIDTH-1:0] wdata,
   output logic [DEPTH-1:0] ptr,
   output logic [WIDTH-1:0] top
);

   logic [WIDTH-1:0] mem [2**DEPTH];
   logic [DEPTH-1:0] nxt;

   assign nxt = ptr + DEPTH'(stack_delta(delta));
   assign top = mem[ptr];

   // pointer moves every cycle, wrapping silently
   always_ff @(posedge clk) begin
      if (rst)
         ptr <= '0;
      else
         ptr <= nxt;
   end

   // entry at the new pointer position takes the write data
   always_ff @(posedge clk) begin
      if (we && !rst)
         mem[nxt] <= wdata;
   end

endmodule

// File: rtl/j4.sv
// j4: 16-bit J1-style dual-stack Forth CPU core, one instruction per cycle.
// Define J4_DEBUG_EN to expose the debug port group mirroring internal state.
module j4
   import j4_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [15:0]      instr,
   output logic [PC_W-1:0]  pc,
   output logic             io_we,
   output logic             io_re,
   output logic [WIDTH-1:0] io_ptr,
   output logic [WIDTH-1:0] io_out,
   input  logic [WIDTH-1:0] io_in
`ifdef J4_DEBUG_EN
   ,
   output logic [PC_W-1:0]  pc_dut,
   output logic [DEPTH-1:0] dsp_dut,
   output logic [WIDTH-1:0] dst0_dut,
   output logic [WIDTH-1:0] dst1_dut,
   output logic             ds_we_dut,
   output logic [DEPTH-1:0] rsp_dut,
   output logic [WIDTH-1:0] rst0_dut
`endif
);

   logic [WIDTH-1:0] t, t_n, n, r, alu, rs_wd;
   logic [PC_W-1:0]  pc_n, pc_inc, target;
   logic [DEPTH-1:0] dsp, rsp;
   logic [1:0]       ds_d, rs_d;
   logic             ds_we, rs_we;
   cls_t             cls;
   alu_op_t          op;

   assign cls    = decode_cls(instr);
   assign op     = alu_op_t'(instr[11:8]);
   assign pc_inc = pc + 1'b1;
   assign target = instr[12:0];

   assign io_ptr = t;
   assign io_out = n;
   assign io_we  = !rst && cls == ALU && instr[B_WE];
   assign io_re  = !rst && cls == ALU && instr[B_RE];

   // ALU result from the pre-update T, N, R and pointers
   always_comb begin
      alu = t;
      unique case (op)
         OP_T:   alu = t;
         OP_N:   alu = n;
         OP_ADD: alu = t + n;
         OP_AND: alu = t & n;
         OP_OR:  alu = t | n;
         OP_XOR: alu = t ^ n;
         OP_INV: alu = ~t;
         OP_EQ:  alu = {WIDTH{n == t}};
         OP_LT:  alu = {WIDTH{$signed(n) < $signed(t)}};
         OP_SHR: alu = n >> t[3:0];
         OP_DEC: alu = t - 1'b1;
         OP_R:   alu = r;
         OP_IO:  alu = io_in;
         OP_SHL: alu = n << t[3:0];
         OP_SP:  alu = WIDTH'({rsp, dsp});
         OP_ULT: alu = {WIDTH{n < t}};
      endcase
   end

   // next pc, next T and stack controls per instruction class
   always_comb begin
      pc_n  = pc_inc;
      t_n   = t;
      ds_d  = 2'b00;
      ds_we = 1'b0;
      rs_d  = 2'b00;
      rs_we = 1'b0;
      rs_wd = t;
      unique case (cls)
         LIT: begin
            t_n   = WIDTH'(instr[14:0]);
            ds_d  = 2'b01;
            ds_we = 1'b1;
         end
         JMP: pc_n = target;
         JZ: begin
            if (t == '0)
               pc_n = target;
            t_n  = n;
            ds_d = 2'b11;
         end
         CALL: begin
            rs_d  = 2'b01;
            rs_we = 1'b1;
            rs_wd = WIDTH'(pc_inc);
            pc_n  = target;
         end
         ALU: begin
            t_n   = alu;
            ds_d  = instr[1:0];
            rs_d  = instr[3:2];
            ds_we = instr[B_TN];
            rs_we = instr[B_TR];
            if (instr[B_RPC])
               pc_n = r[PC_W-1:0];
         end
         default: ;
      endcase
   end

   // pc and T registers
   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= '0;
         t  <= '0;
      end else begin
         pc <= pc_n;
         t  <= t_n;
      end
   end

   j4_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ds (
      .clk   (clk),
      .rst   (rst),
      .delta (ds_d),
      .we    (ds_we),
      .wdata (t),
      .ptr   (dsp),
      .top   (n)
   );

   j4_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rs (
      .clk   (clk),
      .rst   (rst),
      .delta (rs_d),
      .we    (rs_we),
      .wdata (rs_wd),
      .ptr   (rsp),
      .top   (r)
   );

`ifdef J4_DEBUG_EN
   assign pc_dut    = pc;
   assign dsp_dut   = dsp;
   assign dst0_dut  = t;
   assign dst1_dut  = n;
   assign ds_we_dut = ds_we;
   assign rsp_dut   = rsp;
   assign rst0_dut  = r;
`endif

endmodule

// File: tb/tb_j4.sv
// j4 directed bench: hand-computed vectors observed through pc and io ports.
// Stack pointers and R are read back with ALU ops (op14 / op11) into T.
module tb_j4;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] instr;
   logic [12:0] pc;
   logic        io_we, io_re;
   logic [15:0] io_ptr, io_out, io_in;
   logic [15:0] ram [256];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   j4 dut (
      .clk    (clk),
      .rst    (rst),
      .instr  (instr),
      .pc     (pc),
      .io_we  (io_we),
      .io_re  (io_re),
      .io_ptr (io_ptr),
      .io_out (io_out),
      .io_in  (io_in)
   );

   always @(posedge clk) begin
      if (io_we) ram[io_ptr[7:0]] <= io_out;
      if (io_re) io_in <= ram[io_ptr[7:0]];
   end

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic exec(input logic [15:0] i);
      instr = i;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int k = 0; k < 256; k++) ram[k] = 16'h0;
      io_in = 16'h0;
      rst   = 1'b1;
      instr = 16'h6030;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_pc", {3'b0, pc}, 16'h0000);
      chk("rst_t", io_ptr, 16'h0000);
      chk("rst_we", {15'b0, io_we}, 16'h0000);
      chk("rst_re", {15'b0, io_re}, 16'h0000);
      rst = 1'b0;

      exec(16'h8005);
      exec(16'h8003);
      exec(16'h6203);
      chk("add_t", io_ptr, 16'h0008);
      chk("add_pc", {3'b0, pc}, 16'h0003);
      exec(16'h6E81);
      chk("add_sp", io_ptr, 16'h0001);
      chk("add_n", io_out, 16'h0008);
      exec(16'h6103);

      exec(16'h9234);
      exec(16'h8040);
      instr = 16'h6123;
      #1;
      chk("st_we", {15'b0, io_we}, 16'h0001);
      chk("st_ptr", io_ptr, 16'h0040);
      chk("st_out", io_out, 16'h1234);
      @(posedge clk); #1;
      chk("st_ram", ram[8'h40], 16'h1234);
      chk("st_t", io_ptr, 16'h1234);

      exec(16'h8040);
      instr = 16'h6010;
      #1;
      chk("ld_re", {15'b0, io_re}, 16'h0001);
      chk("ld_ptr", io_ptr, 16'h0040);
      @(posedge clk); #1;
      exec(16'h6C00);
      chk("ld_t", io_ptr, 16'h1234);

      exec(16'h6A00);
      chk("dec", io_ptr, 16'h1233);
      exec(16'h6503);
      chk("xor", io_ptr, 16'h0007);
      exec(16'h6600);
      chk("inv", io_ptr, 16'hFFF8);
      exec(16'h8001);
      exec(16'h6800);
      chk("slt", io_ptr, 16'hFFFF);
      exec(16'h6103);
      exec(16'h8001);
      exec(16'h6F00);
      chk("ult", io_ptr, 16'h0000);
      chk("alu_pc", {3'b0, pc}, 16'h0013);

      exec(16'h0010);
      chk("jmp_pc", {3'b0, pc}, 16'h0010);
      exec(16'h4020);
      chk("call_pc", {3'b0, pc}, 16'h0020);
      exec(16'h6B81);
      chk("call_r", io_ptr, 16'h0011);
      exec(16'h6E81);
      chk("call_sp", io_ptr, 16'h0024);
      exec(16'h700C);
      chk("ret_pc", {3'b0, pc}, 16'h0011);
      exec(16'h6E81);
      chk("ret_sp", io_ptr, 16'h0005);

      exec(16'h8000);
      exec(16'h2030);
      chk("jz0_pc", {3'b0, pc}, 16'h0030);
      chk("jz0_t", io_ptr, 16'h0005);
      exec(16'h6E81);
      chk("jz0_sp", io_ptr, 16'h0006);
      exec(16'h6103);
      exec(16'h8001);
      exec(16'h2030);
      chk("jz1_pc", {3'b0, pc}, 16'h0034);
      chk("jz1_t", io_ptr, 16'h0005);
      exec(16'h6E81);
      chk("jz1_sp", io_ptr, 16'h0006);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
